// File: rtl/counter_mod.sv
// Modulo-N up/down counter with clock-enable prescaler, clamped synchronous load
// and wrap reporting; shared timebase for the exercise designs.
module counter_mod #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     PRESCALE = 1,
    parameter longint unsigned INIT     = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_wrap,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             wrap_sticky,
    output logic             terminal
);

    localparam int unsigned      PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_CNT = WIDTH'(INIT);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    // Declaration initialisers make the power-up state equal the reset state.
    logic [WIDTH-1:0] r_count  = INIT_CNT;
    logic [PSC_W-1:0] r_psc    = '0;
    logic             r_tick   = 1'b0;
    logic             r_wrap   = 1'b0;
    logic             r_sticky = 1'b0;

    logic             w_at_top;
    logic             w_at_zero;
    logic             w_step;
    logic             w_boundary;
    logic [WIDTH-1:0] w_count_step;
    logic [WIDTH-1:0] w_load_val;

    always_comb begin
        w_at_top     = (r_count == MAX_CNT);
        w_at_zero    = (r_count == '0);
        w_step       = enable && (r_psc == PSC_LAST);
        w_boundary   = up ? w_at_top : w_at_zero;
        w_count_step = r_count;
        if (up) begin
            w_count_step = w_at_top ? '0 : r_count + WIDTH'(1);
        end else begin
            w_count_step = w_at_zero ? MAX_CNT : r_count - WIDTH'(1);
        end
        // Out-of-range load values clamp to the top of the modulus range.
        w_load_val = (load_value > MAX_CNT) ? MAX_CNT : load_value;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= INIT_CNT;
            r_psc    <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
            r_sticky <= 1'b0;
        end else if (load) begin
            r_count <= w_load_val;
            r_psc   <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            if (clear_wrap) begin
                r_sticky <= 1'b0;
            end
        end else begin
            r_tick <= w_step;
            r_wrap <= w_step && w_boundary;
            if (enable) begin
                if (w_step) begin
                    r_psc   <= '0;
                    r_count <= w_count_step;
                end else begin
                    r_psc <= r_psc + PSC_W'(1);
                end
            end
            // A wrap in the same cycle as clear_wrap keeps the flag set.
            if (w_step && w_boundary) begin
                r_sticky <= 1'b1;
            end else if (clear_wrap) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign count       = r_count;
    assign tick        = r_tick;
    assign wrap        = r_wrap;
    assign wrap_sticky = r_sticky;
    assign terminal    = up ? w_at_top : w_at_zero;

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: directed scenarios on two configurations plus a
// randomized run against an integer modular-arithmetic reference model.
module tb_counter_mod;

    localparam int MOD = 10;

    logic       clk = 1'b0;
    logic       rst[2], en[2], upd[2], ld[2], clr[2];
    logic [3:0] lv[2];
    logic [3:0] cnt[2];
    logic       tk[2], wr[2], st[2], term[2];

    int checks = 0;
    int errors = 0;

    // Reference model: count value, enabled cycles since last reset/load/step.
    int m_cnt[2];
    int m_en[2];
    bit m_tk[2], m_wr[2], m_st[2];

    always #5 clk = ~clk;

    counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .INIT(0)) dut_a (
        .clock(clk), .reset(rst[0]), .enable(en[0]), .up(upd[0]), .load(ld[0]),
        .load_value(lv[0]), .clear_wrap(clr[0]), .count(cnt[0]), .tick(tk[0]),
        .wrap(wr[0]), .wrap_sticky(st[0]), .terminal(term[0])
    );

    counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .INIT(5)) dut_b (
        .clock(clk), .reset(rst[1]), .enable(en[1]), .up(upd[1]), .load(ld[1]),
        .load_value(lv[1]), .clear_wrap(clr[1]), .count(cnt[1]), .tick(tk[1]),
        .wrap(wr[1]), .wrap_sticky(st[1]), .terminal(term[1])
    );

    function automatic int p_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int init_of(int i);
        return (i == 0) ? 0 : 5;
    endfunction

    // Advance the model with the inputs currently applied, then clock the DUTs.
    task automatic step_clk();
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_cnt[i] = init_of(i); m_en[i] = 0;
                m_tk[i] = 0; m_wr[i] = 0; m_st[i] = 0;
            end else if (ld[i]) begin
                m_cnt[i] = (int'(lv[i]) >= MOD) ? MOD - 1 : int'(lv[i]);
                m_en[i] = 0; m_tk[i] = 0; m_wr[i] = 0;
                if (clr[i]) m_st[i] = 0;
            end else begin
                m_tk[i] = 0; m_wr[i] = 0;
                if (en[i]) begin
                    m_en[i]++;
                    if (m_en[i] == p_of(i)) begin
                        m_en[i] = 0;
                        m_tk[i] = 1;
                        m_wr[i] = upd[i] ? (m_cnt[i] == MOD - 1) : (m_cnt[i] == 0);
                        m_cnt[i] = (m_cnt[i] + (upd[i] ? 1 : MOD - 1)) % MOD;
                    end
                end
                if (m_wr[i]) m_st[i] = 1;
                else if (clr[i]) m_st[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) rst[i] = 1'b1;
        step_clk();
        step_clk();
        checks++;
        if (cnt[0] !== 4'd0) begin
            errors++; $display("FAIL reset_cnt_a got %0d want 0", cnt[0]);
        end
        checks++;
        if (cnt[1] !== 4'd5) begin
            errors++; $display("FAIL reset_cnt_b got %0d want 5", cnt[1]);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({tk[i], wr[i], st[i]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_flags dut%0d got tick/wrap/sticky %b%b%b want 000",
                         i, tk[i], wr[i], st[i]);
            end
        end
        for (int i = 0; i < 2; i++) rst[i] = 1'b0;
    endtask

    task automatic test_up_wrap();
        en[0] = 1'b1; upd[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step_clk();
            checks++;
            if ({cnt[0], tk[0], wr[0]} !== {4'(k % 10), 1'b1, (k == 10)}) begin
                errors++;
                $display("FAIL up_seq step %0d got cnt=%0d tick=%b wrap=%b want cnt=%0d tick=1 wrap=%b",
                         k, cnt[0], tk[0], wr[0], k % 10, (k == 10));
            end
        end
        checks++;
        if (st[0] !== 1'b1) begin
            errors++; $display("FAIL up_sticky got %b want 1", st[0]);
        end
    endtask

    task automatic test_down();
        upd[0] = 1'b0;
        #1;
        checks++;
        if (term[0] !== 1'b1) begin
            errors++; $display("FAIL down_term_at0 got %b want 1", term[0]);
        end
        for (int k = 0; k < 3; k++) begin
            step_clk();
            checks++;
            if ({cnt[0], wr[0], term[0]} !== {4'(9 - k), (k == 0), 1'b0}) begin
                errors++;
                $display("FAIL down_seq %0d got cnt=%0d wrap=%b term=%b want cnt=%0d wrap=%b term=0",
                         k, cnt[0], wr[0], term[0], 9 - k, (k == 0));
            end
            if (k == 0) begin
                upd[0] = 1'b1;
                #1;
                checks++;
                if (term[0] !== 1'b1) begin
                    errors++; $display("FAIL term_comb_up9 got %b want 1", term[0]);
                end
                upd[0] = 1'b0;
                #1;
            end
        end
        en[0] = 1'b0;
    endtask

    task automatic test_prescale();
        bit e_seq[7] = '{1, 1, 0, 0, 0, 1, 1};
        rst[1] = 1'b1;
        step_clk();
        rst[1] = 1'b0; en[1] = 1'b1; upd[1] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step_clk();
            checks++;
            if ({cnt[1], tk[1]} !== {(k == 4) ? 4'd6 : 4'd5, (k == 4)}) begin
                errors++;
                $display("FAIL psc_first %0d got cnt=%0d tick=%b want cnt=%0d tick=%b",
                         k, cnt[1], tk[1], (k == 4) ? 6 : 5, (k == 4));
            end
        end
        for (int k = 0; k < 7; k++) begin
            en[1] = e_seq[k];
            step_clk();
            checks++;
            if ({cnt[1], tk[1]} !== {(k == 6) ? 4'd7 : 4'd6, (k == 6)}) begin
                errors++;
                $display("FAIL psc_enable_gap %0d got cnt=%0d tick=%b want cnt=%0d tick=%b",
                         k, cnt[1], tk[1], (k == 6) ? 7 : 6, (k == 6));
            end
        end
    endtask

    task automatic test_load();
        for (int k = 0; k < 3; k++) step_clk();
        checks++;
        if (cnt[1] !== 4'd7) begin
            errors++; $display("FAIL load_pre got %0d want 7", cnt[1]);
        end
        ld[1] = 1'b1; lv[1] = 4'd12;
        step_clk();
        ld[1] = 1'b0;
        checks++;
        if ({cnt[1], tk[1], wr[1]} !== {4'd9, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_clamp got cnt=%0d tick=%b wrap=%b want cnt=9 tick=0 wrap=0",
                     cnt[1], tk[1], wr[1]);
        end
        for (int k = 1; k <= 4; k++) begin
            step_clk();
            checks++;
            if ({cnt[1], tk[1], wr[1]} !== {(k == 4) ? 4'd0 : 4'd9, (k == 4), (k == 4)}) begin
                errors++;
                $display("FAIL load_next_step %0d got cnt=%0d tick=%b wrap=%b want cnt=%0d",
                         k, cnt[1], tk[1], wr[1], (k == 4) ? 0 : 9);
            end
        end
        checks++;
        if (st[1] !== 1'b1) begin
            errors++; $display("FAIL load_sticky_set got %b want 1", st[1]);
        end
    endtask

    task automatic test_clear_wrap();
        en[0] = 1'b1; upd[0] = 1'b1;
        step_clk();
        step_clk();
        checks++;
        if (cnt[0] !== 4'd9) begin
            errors++; $display("FAIL clr_pre got %0d want 9", cnt[0]);
        end
        clr[0] = 1'b1;
        step_clk();
        checks++;
        if ({cnt[0], wr[0], st[0]} !== {4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL clr_same_cycle got cnt=%0d wrap=%b sticky=%b want cnt=0 wrap=1 sticky=1",
                     cnt[0], wr[0], st[0]);
        end
        step_clk();
        clr[0] = 1'b0;
        checks++;
        if (st[0] !== 1'b0) begin
            errors++; $display("FAIL clr_alone got %b want 0", st[0]);
        end
        en[0] = 1'b0;
    endtask

    task automatic test_init_reset();
        ld[1] = 1'b1; lv[1] = 4'd7;
        step_clk();
        ld[1] = 1'b0;
        step_clk();
        step_clk();
        checks++;
        if ({cnt[1], st[1]} !== {4'd7, 1'b1}) begin
            errors++;
            $display("FAIL init_pre got cnt=%0d sticky=%b want cnt=7 sticky=1", cnt[1], st[1]);
        end
        rst[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step_clk();
            checks++;
            if ({cnt[1], st[1], tk[1]} !== {4'd5, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL init_reset_hold %0d got cnt=%0d sticky=%b tick=%b want cnt=5 sticky=0 tick=0",
                         k, cnt[1], st[1], tk[1]);
            end
        end
        rst[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step_clk();
            checks++;
            if (cnt[1] !== ((k == 4) ? 4'd6 : 4'd5)) begin
                errors++;
                $display("FAIL init_full_period %0d got %0d want %0d", k, cnt[1], (k == 4) ? 6 : 5);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                rst[i] = ($urandom_range(63) == 0);
                ld[i]  = ($urandom_range(15) == 0);
                lv[i]  = 4'($urandom_range(15));
                en[i]  = ($urandom_range(3) != 0);
                clr[i] = ($urandom_range(7) == 0);
                if ($urandom_range(7) == 0) upd[i] = ~upd[i];
            end
            step_clk();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (cnt[i] !== 4'(m_cnt[i])) begin
                    errors++; $display("FAIL rnd_cnt dut%0d cyc %0d got %0d want %0d", i, n, cnt[i], m_cnt[i]);
                end
                checks++;
                if (tk[i] !== m_tk[i]) begin
                    errors++; $display("FAIL rnd_tick dut%0d cyc %0d got %b want %b", i, n, tk[i], m_tk[i]);
                end
                checks++;
                if (wr[i] !== m_wr[i]) begin
                    errors++; $display("FAIL rnd_wrap dut%0d cyc %0d got %b want %b", i, n, wr[i], m_wr[i]);
                end
                checks++;
                if (st[i] !== m_st[i]) begin
                    errors++; $display("FAIL rnd_sticky dut%0d cyc %0d got %b want %b", i, n, st[i], m_st[i]);
                end
                checks++;
                if (term[i] !== (upd[i] ? (m_cnt[i] == MOD - 1) : (m_cnt[i] == 0))) begin
                    errors++; $display("FAIL rnd_term dut%0d cyc %0d got %b", i, n, term[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; upd[i] = 1'b1; ld[i] = 1'b0;
            clr[i] = 1'b0; lv[i] = 4'd0;
            m_cnt[i] = init_of(i); m_en[i] = 0;
            m_tk[i] = 0; m_wr[i] = 0; m_st[i] = 0;
        end
        test_reset();
        test_up_wrap();
        test_down();
        test_prescale();
        test_load();
        test_clear_wrap();
        test_init_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
